// File: rtl/driver_monitor.sv
// Bus driver fed by a request FIFO, plus a monitor that captures each completed transfer.
// Optional data-match coverage counter enabled by defining DRIVER_MONITOR_COV_EN.
module driver_monitor #(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 8,
    parameter int                DEPTH      = 4,
    parameter logic [DATA_W-1:0] MATCH_DATA = 'h55
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data,
    output logic              mon_valid,
    output logic [ADDR_W-1:0] mon_addr,
    output logic [DATA_W-1:0] data_out,
    output logic [15:0]       txn_count,
    output logic [7:0]        match_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [ENT_W-1:0]  r_mem [DEPTH];
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic              r_bus_valid;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_data;
    logic              r_mon_valid;
    logic [ADDR_W-1:0] r_mon_addr;
    logic [DATA_W-1:0] r_data_out;
    logic [15:0]       r_txn_count;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_cap;
    logic [ENT_W-1:0]  w_head;

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_push  = req_valid && !w_full;
    assign w_cap   = r_bus_valid && bus_ready;
    assign w_pop   = !w_empty && (!r_bus_valid || bus_ready);
    assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= {req_addr, req_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    // The bus stage reloads whenever it is idle or its transfer completes this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bus_valid <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_data  <= '0;
        end else if (!r_bus_valid || bus_ready) begin
            r_bus_valid <= !w_empty;
            if (!w_empty) begin
                r_bus_addr <= w_head[ENT_W-1:DATA_W];
                r_bus_data <= w_head[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mon_valid <= 1'b0;
            r_mon_addr  <= '0;
            r_data_out  <= '0;
            r_txn_count <= '0;
        end else begin
            r_mon_valid <= w_cap;
            if (w_cap) begin
                r_mon_addr  <= r_bus_addr;
                r_data_out  <= r_bus_data;
                r_txn_count <= r_txn_count + 16'd1;
            end
        end
    end

`ifdef DRIVER_MONITOR_COV_EN
    logic [7:0] r_match_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_match_count <= '0;
        end else if (w_cap && (r_bus_data == MATCH_DATA) && (r_match_count != 8'hFF)) begin
            r_match_count <= r_match_count + 8'd1;
        end
    end

    assign match_count = r_match_count;
`else
    logic w_unused_match;

    assign w_unused_match = ^MATCH_DATA;
    assign match_count    = 8'h00;
`endif

    assign req_ready = !w_full;
    assign bus_valid = r_bus_valid;
    assign bus_addr  = r_bus_addr;
    assign bus_data  = r_bus_data;
    assign mon_valid = r_mon_valid;
    assign mon_addr  = r_mon_addr;
    assign data_out  = r_data_out;
    assign txn_count = r_txn_count;

endmodule

// File: tb/tb_driver_monitor.sv
// Directed bench for driver_monitor: single transfer, back-pressure, full FIFO,
// back-to-back transfers and reset mid-transfer.
module tb_driver_monitor;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_addr;
    logic [7:0]  req_data;
    logic        bus_valid;
    logic        bus_ready;
    logic [7:0]  bus_addr;
    logic [7:0]  bus_data;
    logic        mon_valid;
    logic [7:0]  mon_addr;
    logic [7:0]  data_out;
    logic [15:0] txn_count;
    logic [7:0]  match_count;

    int n_cmp = 0;
    int n_err = 0;

`ifdef DRIVER_MONITOR_COV_EN
    localparam int COV = 1;
`else
    localparam int COV = 0;
`endif

    driver_monitor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .bus_valid   (bus_valid),
        .bus_ready   (bus_ready),
        .bus_addr    (bus_addr),
        .bus_data    (bus_data),
        .mon_valid   (mon_valid),
        .mon_addr    (mon_addr),
        .data_out    (data_out),
        .txn_count   (txn_count),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_bus_valid"}, 32'(bus_valid), 32'd0);
        check({tag, "_bus_addr"},  32'(bus_addr),  32'd0);
        check({tag, "_bus_data"},  32'(bus_data),  32'd0);
        check({tag, "_mon_valid"}, 32'(mon_valid), 32'd0);
        check({tag, "_mon_addr"},  32'(mon_addr),  32'd0);
        check({tag, "_data_out"},  32'(data_out),  32'd0);
        check({tag, "_txn"},       32'(txn_count), 32'd0);
        check({tag, "_match"},     32'(match_count), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    logic [7:0] b2b_data [3];
    int accepted;
    int pulses;

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        bus_ready = 1'b0;
        do_reset();
        tick();
        check_idle("reset");

        // Single transfer
        bus_ready = 1'b1;
        req_valid = 1'b1; req_addr = 8'hAA; req_data = 8'h55;
        tick();
        req_valid = 1'b0;
        check("single_n_bus_valid", 32'(bus_valid), 32'd0);
        tick();
        check("single_n1_bus_valid", 32'(bus_valid), 32'd1);
        check("single_n1_bus_addr",  32'(bus_addr),  32'hAA);
        check("single_n1_bus_data",  32'(bus_data),  32'h55);
        check("single_n1_mon_valid", 32'(mon_valid), 32'd0);
        tick();
        check("single_n2_mon_valid", 32'(mon_valid), 32'd1);
        check("single_n2_mon_addr",  32'(mon_addr),  32'hAA);
        check("single_n2_data_out",  32'(data_out),  32'h55);
        check("single_n2_txn",       32'(txn_count), 32'd1);
        check("single_n2_match",     32'(match_count), 32'(COV));
        check("single_n2_bus_valid", 32'(bus_valid), 32'd0);
        tick();
        check("single_n3_mon_valid", 32'(mon_valid), 32'd0);
        check("single_n3_data_hold", 32'(data_out),  32'h55);

        // Back-pressure
        bus_ready = 1'b0;
        req_valid = 1'b1; req_addr = 8'h11; req_data = 8'h22;
        tick();
        req_valid = 1'b0;
        tick();
        check("bp_bus_valid_rise", 32'(bus_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 32'(bus_valid), 32'd1);
            check("bp_hold_addr",  32'(bus_addr),  32'h11);
            check("bp_hold_data",  32'(bus_data),  32'h22);
            check("bp_no_mon",     32'(mon_valid), 32'd0);
        end
        bus_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mon_valid) pulses++;
        end
        check("bp_pulses",   32'(pulses),    32'd1);
        check("bp_mon_addr", 32'(mon_addr),  32'h11);
        check("bp_data_out", 32'(data_out),  32'h22);
        check("bp_txn",      32'(txn_count), 32'd2);

        // Full FIFO: occupy the bus stage first, then push 5
        bus_ready = 1'b0;
        req_valid = 1'b1; req_addr = 8'h3F; req_data = 8'h4F;
        tick();
        req_valid = 1'b0;
        tick();
        check("full_bus_busy", 32'(bus_valid), 32'd1);
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_addr  = 8'h30 + 8'(i);
            req_data  = 8'h40 + 8'(i);
            if (req_ready) accepted++;
            tick();
            if (i == 3) check("full_ready_drop", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        check("full_accepted", 32'(accepted), 32'd4);
        check("full_ready_low", 32'(req_ready), 32'd0);
        bus_ready = 1'b1;
        tick();
        check("full_cap0_valid", 32'(mon_valid), 32'd1);
        check("full_cap0_addr",  32'(mon_addr),  32'h3F);
        check("full_cap0_data",  32'(data_out),  32'h4F);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("full_cap_valid", 32'(mon_valid), 32'd1);
            check("full_cap_addr",  32'(mon_addr),  32'h30 + 32'(k));
            check("full_cap_data",  32'(data_out),  32'h40 + 32'(k));
        end
        tick();
        check("full_end_mon",   32'(mon_valid), 32'd0);
        check("full_end_bus",   32'(bus_valid), 32'd0);
        check("full_end_txn",   32'(txn_count), 32'd7);
        check("full_end_ready", 32'(req_ready), 32'd1);

        // Back-to-back, from a fresh reset
        bus_ready = 1'b0;
        do_reset();
        bus_ready = 1'b1;
        b2b_data[0] = 8'h55; b2b_data[1] = 8'h00; b2b_data[2] = 8'h55;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_addr  = 8'h50 + 8'(i);
            req_data  = b2b_data[i];
            tick();
            if (i == 0) check("b2b_e1_bus_valid", 32'(bus_valid), 32'd0);
            if (i == 1) check("b2b_e2_bus_data",  32'(bus_data),  32'h55);
            if (i == 2) check("b2b_e3_data_out",  32'(data_out),  32'h55);
            if (i >= 1) check("b2b_bus_valid",    32'(bus_valid), 32'd1);
        end
        req_valid = 1'b0;
        tick();
        check("b2b_e4_mon",      32'(mon_valid), 32'd1);
        check("b2b_e4_data_out", 32'(data_out),  32'h00);
        check("b2b_e4_bus_valid", 32'(bus_valid), 32'd1);
        tick();
        check("b2b_e5_mon",      32'(mon_valid), 32'd1);
        check("b2b_e5_data_out", 32'(data_out),  32'h55);
        check("b2b_e5_mon_addr", 32'(mon_addr),  32'h52);
        check("b2b_e5_bus_valid", 32'(bus_valid), 32'd0);
        check("b2b_txn",         32'(txn_count), 32'd3);
        check("b2b_match",       32'(match_count), 32'(2 * COV));

        // Reset mid-transfer with two entries queued
        bus_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_addr  = 8'h70 + 8'(i);
            req_data  = 8'h55;
            tick();
        end
        req_valid = 1'b0;
        check("rst_pre_bus_valid", 32'(bus_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus_ready = 1'b1;
        check_idle("rst_mid");
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mon_valid || bus_valid) pulses++;
        end
        check("rst_no_activity", 32'(pulses),    32'd0);
        check("rst_after_txn",   32'(txn_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/driver_monitor.md
DRIVER_MONITOR -- requirements
Module: driver_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address width.
REQ-002 SHALL have parameter DATA_W, default 8, data width.
REQ-003 SHALL have parameter DEPTH, default 4, driver request FIFO depth, power of two, at least 2.
REQ-004 SHALL have parameter MATCH_DATA, default 8'h55, data value counted by the coverage counter.
REQ-005 SHALL have one clock and a synchronous, active-low reset:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have the following driver request ports:
- req_valid  in  1  request present.
- req_ready  out  1  driver can accept a request.
- req_addr  in  ADDR_W  request address.
- req_data  in  DATA_W  request data.
REQ-007 SHALL have the following bus ports:
- bus_valid  out  1  bus transfer valid.
- bus_ready  in  1  bus target accepts the transfer.
- bus_addr  out  ADDR_W  bus address.
- bus_data  out  DATA_W  bus data.
REQ-008 SHALL have the following monitor ports:
- mon_valid  out  1  one-cycle pulse when a bus transfer has been captured.
- mon_addr  out  ADDR_W  captured address.
- data_out  out  DATA_W  last captured data.
- txn_count  out  16  number of captured transfers.
- match_count  out  8  coverage count of transfers whose data equals MATCH_DATA.

Function
REQ-009 Driver SHALL push {req_addr, req_data} into the FIFO on any cycle where req_valid and req_ready are both 1.
REQ-010 req_ready SHALL equal NOT full; a pop in the same cycle SHALL NOT raise req_ready.
REQ-011 When bus_valid is 0 and the FIFO is not empty, the driver SHALL pop the head entry and register it onto bus_addr/bus_data with bus_valid=1 at the next edge.
REQ-012 While bus_valid is 1 and bus_ready is 0, bus_valid, bus_addr and bus_data SHALL hold stable.
REQ-013 A transfer SHALL complete on the edge where bus_valid and bus_ready are both 1.
REQ-014 On the completing edge, if the FIFO is not empty, the driver SHALL load the next entry and keep bus_valid=1 (back-to-back transfers); otherwise bus_valid SHALL drop to 0.
REQ-015 Minimum latency: a request accepted at edge N into an empty FIFO with the bus idle SHALL produce bus_valid=1 after edge N+1.
REQ-016 Monitor SHALL sample bus_addr/bus_data on every completing edge and, after that edge, assert mon_valid=1 for exactly one cycle with mon_addr and data_out set to the sampled values.
REQ-017 data_out and mon_addr SHALL hold their values until the next capture.
REQ-018 txn_count SHALL increment by 1 per capture and wrap from 16'hFFFF to 0.
REQ-019 The FIFO SHALL use wrap-around pointers with an extra bit for full/empty detection.
REQ-020 A simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-021 A push while full SHALL be ignored, and the FIFO contents SHALL be unchanged.

Reset
REQ-022 When rst_n=0 at a clock edge, the block SHALL:
- empty the FIFO;
- clear bus_valid, bus_addr, bus_data, mon_valid, mon_addr, data_out, txn_count and match_count to 0;
- drive req_ready=1 from the first cycle after reset.
REQ-023 A reset asserted mid-transfer SHALL abort the transfer with no capture, and all queued requests SHALL be discarded.

Configuration
REQ-024 With macro DRIVER_MONITOR_COV_EN defined, match_count SHALL increment on each capture whose data equals MATCH_DATA and saturate at 8'hFF.
REQ-025 Without DRIVER_MONITOR_COV_EN, match_count SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-026 Single transfer: reset, then req addr=8'hAA data=8'h55 with bus_ready=1.
- bus_valid is 1 at N+1 with bus_addr=AA, bus_data=55.
- mon_valid pulses at N+2 with mon_addr=AA, data_out=55.
- txn_count=1, and match_count=1 when COV_EN is defined.
REQ-027 Back-pressure: bus_ready=0 for 5 cycles after bus_valid rises.
- bus_addr/bus_data stay stable and no mon_valid occurs.
- After bus_ready=1, exactly one capture occurs.
REQ-028 Full FIFO: with bus_ready=0, push 5 requests.
- req_ready drops after 4 accepted requests, and the 5th is not accepted.
- After releasing bus_ready, captures occur in push order on consecutive cycles.
REQ-029 Back-to-back: 3 requests with data 55, 00, 55 and bus_ready held 1.
- bus_valid stays high across the transfers.
- data_out sequence is 55, 00, 55; txn_count=3; match_count=2 (COV_EN defined) or 0 (COV_EN undefined).
REQ-030 Reset mid-transfer: assert rst_n=0 while bus_valid=1 and the FIFO holds 2 entries.
- After reset, all outputs are 0, req_ready=1, and no capture follows.
